// File: rtl/ball_motion.sv
// Ball position/velocity owner: accumulates collision side/angle hits during a frame,
// applies them once per frame, then advances the ball in 1/16-pixel fixed point.
module ball_motion #(
    parameter int BALL_SIZE = 16,
    parameter int BAT_WIDTH = 64,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SERVE_Y   = 400
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [4:0]  ballCollision,
    input  logic [2:0]  batCollision,
    input  logic [10:0] batTopLeftX,
    input  logic        launch,
    output logic [10:0] ballTopLeftX,
    output logic [10:0] ballTopLeftY,
    output logic        inPlay,
    output logic        ballLost
);

    localparam logic signed [15:0] SERVE_OFS  = 16'((BAT_WIDTH / 2 - BALL_SIZE / 2) * 16);
    localparam logic signed [15:0] SERVE_Y_FX = 16'(SERVE_Y * 16);
    localparam logic signed [15:0] X_MAX      = 16'((SCREEN_W - BALL_SIZE) * 16);
    localparam logic signed [16:0] X_MAX_W    = 17'((SCREEN_W - BALL_SIZE) * 16);
    localparam logic signed [15:0] Y_LOST     = 16'(SCREEN_H * 16);

    typedef enum logic [2:0] {S_SERVE, S_PLAY, S_APPLY, S_MOVE, S_LOST} state_t;

    state_t             state_reg, state_next;
    logic signed [15:0] x_reg, x_next, y_reg, y_next;
    logic signed [9:0]  vx_reg, vx_next, vy_reg, vy_next;
    logic [3:0]         side_reg, side_next;
    logic [2:0]         angle_reg, angle_next;

    logic [3:0]         hit_side;
    logic [2:0]         hit_angle;
    logic signed [15:0] serve_x;
    logic signed [9:0]  ang_vx, ang_vy, vx_t, vy_t;
    logic signed [16:0] x_sum, y_sum;
    logic signed [15:0] y_new;

    function automatic logic signed [9:0] mag(input logic signed [9:0] v);
        return v[9] ? -v : v;
    endfunction

    assign hit_side  = ballCollision[4] ? ballCollision[3:0] : 4'b0000;
    assign hit_angle = (ballCollision[4] && ballCollision[1]) ? batCollision : 3'b000;
    assign serve_x   = $signed({1'b0, batTopLeftX, 4'b0000}) + SERVE_OFS;
    assign x_sum     = 17'(x_reg) + 17'(vx_reg);
    assign y_sum     = 17'(y_reg) + 17'(vy_reg);
    assign y_new     = y_sum[16] ? 16'sd0 : y_sum[15:0];

    // Bat-angle steering table, speed 64 in 1/16 px per frame.
    always_comb begin
        ang_vx = 10'sd0;
        ang_vy = 10'sd0;
        case (angle_reg)
            3'b001:  begin ang_vx = -10'sd55; ang_vy = -10'sd32; end
            3'b010:  begin ang_vx = -10'sd45; ang_vy = -10'sd45; end
            3'b011:  begin ang_vx = -10'sd32; ang_vy = -10'sd55; end
            3'b100:  begin ang_vx =  10'sd0;  ang_vy = -10'sd64; end
            3'b101:  begin ang_vx =  10'sd32; ang_vy = -10'sd55; end
            3'b110:  begin ang_vx =  10'sd45; ang_vy = -10'sd45; end
            3'b111:  begin ang_vx =  10'sd55; ang_vy = -10'sd32; end
            default: begin ang_vx =  10'sd0;  ang_vy =  10'sd0;  end
        endcase
    end

    // Per-frame velocity: bat steering beats side reflections; walls override both.
    always_comb begin
        vx_t = vx_reg;
        vy_t = vy_reg;
        if (angle_reg != 3'b000 && side_reg[1]) begin
            vx_t = ang_vx;
            vy_t = ang_vy;
        end else begin
            case (side_reg[3:2])
                2'b10:   vx_t = mag(vx_reg);
                2'b01:   vx_t = -mag(vx_reg);
                2'b11:   vx_t = -vx_reg;
                default: vx_t = vx_reg;
            endcase
            case (side_reg[1:0])
                2'b10:   vy_t = -mag(vy_reg);
                2'b01:   vy_t = mag(vy_reg);
                2'b11:   vy_t = -vy_reg;
                default: vy_t = vy_reg;
            endcase
        end
        if (x_reg[15] || x_reg == 16'sd0) begin
            vx_t = mag(vx_t);
        end else if (x_reg >= X_MAX) begin
            vx_t = -mag(vx_t);
        end
        if (y_reg[15] || y_reg == 16'sd0) begin
            vy_t = mag(vy_t);
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        vx_next    = vx_reg;
        vy_next    = vy_reg;
        side_next  = side_reg | hit_side;
        angle_next = (hit_angle != 3'b000) ? hit_angle : angle_reg;
        case (state_reg)
            S_SERVE: begin
                x_next     = serve_x;
                y_next     = SERVE_Y_FX;
                vx_next    = 10'sd0;
                vy_next    = 10'sd0;
                side_next  = 4'b0000;
                angle_next = 3'b000;
                if (launch) begin
                    vx_next    = 10'sd45;
                    vy_next    = -10'sd45;
                    state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (startOfFrame) state_next = S_APPLY;
            end
            S_APPLY: begin
                // Pending is consumed here; a hit landing this cycle starts the next frame.
                side_next  = hit_side;
                angle_next = hit_angle;
                vx_next    = vx_t;
                vy_next    = vy_t;
                state_next = S_MOVE;
            end
            S_MOVE: begin
                if (x_sum[16]) begin
                    x_next = 16'sd0;
                end else if (x_sum > X_MAX_W) begin
                    x_next = X_MAX;
                end else begin
                    x_next = x_sum[15:0];
                end
                y_next     = y_new;
                state_next = (y_new >= Y_LOST) ? S_LOST : S_PLAY;
            end
            S_LOST: begin
                vx_next    = 10'sd0;
                vy_next    = 10'sd0;
                state_next = S_SERVE;
            end
            default: state_next = S_SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg <= S_SERVE;
            x_reg     <= SERVE_OFS;
            y_reg     <= SERVE_Y_FX;
            vx_reg    <= 10'sd0;
            vy_reg    <= 10'sd0;
            side_reg  <= 4'b0000;
            angle_reg <= 3'b000;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            vx_reg    <= vx_next;
            vy_reg    <= vy_next;
            side_reg  <= side_next;
            angle_reg <= angle_next;
        end
    end

    assign ballTopLeftX = x_reg[14:4];
    assign ballTopLeftY = y_reg[14:4];
    assign inPlay       = (state_reg == S_PLAY) || (state_reg == S_APPLY) || (state_reg == S_MOVE);
    assign ballLost     = (state_reg == S_LOST);

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: per-cycle comparison against a frame-level model, plus
// hand-computed checkpoints along one serve/bounce/loss scenario.
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [4:0]  ballCollision;
    logic [2:0]  batCollision;
    logic [10:0] batTopLeftX;
    logic        launch;
    logic [10:0] ballTopLeftX;
    logic [10:0] ballTopLeftY;
    logic        inPlay;
    logic        ballLost;

    int n_checks = 0;
    int n_err    = 0;
    int lost_cnt = 0;

    ball_motion dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .ballCollision(ballCollision),
        .batCollision (batCollision),
        .batTopLeftX  (batTopLeftX),
        .launch       (launch),
        .ballTopLeftX (ballTopLeftX),
        .ballTopLeftY (ballTopLeftY),
        .inPlay       (inPlay),
        .ballLost     (ballLost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (1/16 px integers) ----------------
    localparam int M_SERVE = 0, M_WAIT = 1, M_APPLY = 2, M_MOVE = 3, M_LOST = 4;
    localparam int XMAX = (640 - 16) * 16;
    localparam int YLOST = 480 * 16;

    int ang_vx [0:7] = '{0, -55, -45, -32, 0, 32, 45, 55};
    int ang_vy [0:7] = '{0, -32, -45, -55, -64, -55, -45, -32};

    int m_mode = M_SERVE;
    int mx = 384, my = 6400, mvx = 0, mvy = 0;
    logic [3:0] m_side = 4'b0;
    int m_ang = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_mode = M_SERVE; mx = 384; my = 6400; mvx = 0; mvy = 0; m_side = 4'b0; m_ang = 0;
        end else if (m_mode == M_SERVE) begin
            mx = int'(batTopLeftX) * 16 + 384;
            my = 6400; mvx = 0; mvy = 0; m_side = 4'b0; m_ang = 0;
            if (launch) begin
                mvx = 45; mvy = -45; m_mode = M_WAIT;
            end
        end else begin
            int nxt;
            nxt = m_mode;
            if (m_mode == M_WAIT && startOfFrame) nxt = M_APPLY;
            if (m_mode == M_APPLY) begin
                if (m_ang != 0 && m_side[1]) begin
                    mvx = ang_vx[m_ang]; mvy = ang_vy[m_ang];
                end else begin
                    if (m_side[3] && m_side[2]) mvx = -mvx;
                    else if (m_side[3])         mvx = iabs(mvx);
                    else if (m_side[2])         mvx = -iabs(mvx);
                    if (m_side[1] && m_side[0]) mvy = -mvy;
                    else if (m_side[1])         mvy = -iabs(mvy);
                    else if (m_side[0])         mvy = iabs(mvy);
                end
                if (mx <= 0) mvx = iabs(mvx);
                else if (mx >= XMAX) mvx = -iabs(mvx);
                if (my <= 0) mvy = iabs(mvy);
                m_side = 4'b0; m_ang = 0;
                nxt = M_MOVE;
            end
            if (m_mode == M_MOVE) begin
                mx = mx + mvx;
                if (mx < 0) mx = 0;
                if (mx > XMAX) mx = XMAX;
                my = my + mvy;
                if (my < 0) my = 0;
                nxt = (my >= YLOST) ? M_LOST : M_WAIT;
            end
            if (m_mode == M_LOST) begin
                mvx = 0; mvy = 0; nxt = M_SERVE;
            end
            if (ballCollision[4]) begin
                m_side = m_side | ballCollision[3:0];
                if (ballCollision[1] && batCollision != 3'b000) m_ang = int'(batCollision);
            end
            m_mode = nxt;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("ballTopLeftX", int'(ballTopLeftX), (mx / 16) % 2048);
        chk("ballTopLeftY", int'(ballTopLeftY), (my / 16) % 2048);
        chk("inPlay", int'(inPlay), (m_mode >= M_WAIT && m_mode <= M_MOVE) ? 1 : 0);
        chk("ballLost", int'(ballLost), (m_mode == M_LOST) ? 1 : 0);
        if (ballLost) lost_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse(input logic [4:0] bc, input logic [2:0] bat);
        ballCollision = bc;
        batCollision  = bat;
        tick();
        ballCollision = 5'b0;
        batCollision  = 3'b0;
    endtask

    initial begin
        resetN = 1'b1; startOfFrame = 1'b0; ballCollision = 5'b0; batCollision = 3'b0;
        batTopLeftX = 11'd0; launch = 1'b0;
        #1 resetN = 1'b0;
        #1;
        chk("reset_x", int'(ballTopLeftX), 24);
        chk("reset_y", int'(ballTopLeftY), 400);
        chk("reset_inplay", int'(inPlay), 0);
        chk("reset_lost", int'(ballLost), 0);
        repeat (2) tick();
        resetN = 1'b1;
        batTopLeftX = 11'd100;
        tick();
        chk("serve_x", int'(ballTopLeftX), 124);
        chk("serve_y", int'(ballTopLeftY), 400);
        chk("serve_inplay", int'(inPlay), 0);

        launch = 1'b1; tick(); launch = 1'b0;
        chk("launch_inplay", int'(inPlay), 1);
        repeat (3) frame();
        chk("three_frames_x", int'(ballTopLeftX), 132);
        chk("three_frames_y", int'(ballTopLeftY), 391);

        // Same side twice in one frame reflects once.
        pulse(5'b10100, 3'b0); tick(); pulse(5'b10100, 3'b0);
        frame();
        chk("left_twice_x", int'(ballTopLeftX), 129);
        chk("left_twice_y", int'(ballTopLeftY), 388);

        // Right and left together negate Vx.
        pulse(5'b11000, 3'b0); pulse(5'b10100, 3'b0);
        frame();
        chk("both_sides_x", int'(ballTopLeftX), 132);
        chk("both_sides_y", int'(ballTopLeftY), 385);

        // Bat steering M30 overrides the top reflection.
        pulse(5'b10010, 3'b001);
        frame();
        chk("steer_x", int'(ballTopLeftX), 129);
        chk("steer_y", int'(ballTopLeftY), 383);

        // Hit during APPLY waits a frame.
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        pulse(5'b11000, 3'b0);
        repeat (2) tick();
        chk("apply_hit_deferred_x", int'(ballTopLeftX), 125);
        frame();
        chk("apply_hit_applied_x", int'(ballTopLeftX), 129);
        chk("apply_hit_applied_y", int'(ballTopLeftY), 379);

        // Extra startOfFrame during MOVE: one step only.
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        repeat (3) tick();
        chk("double_sof_x", int'(ballTopLeftX), 132);
        chk("double_sof_y", int'(ballTopLeftY), 377);

        // Right wall.
        for (int i = 0; i < 300 && ballTopLeftX != 11'd624; i++) frame();
        chk("right_wall_clamp_x", int'(ballTopLeftX), 624);
        frame();
        chk("right_wall_bounce_x", int'(ballTopLeftX), 620);

        // Top wall.
        for (int i = 0; i < 300 && ballTopLeftY != 11'd0; i++) frame();
        chk("top_wall_y", int'(ballTopLeftY), 0);
        frame();
        chk("top_wall_bounce_y", int'(ballTopLeftY), 2);

        // Fall out of the bottom.
        for (int i = 0; i < 400 && lost_cnt == 0; i++) frame();
        repeat (4) tick();
        chk("lost_pulse_count", lost_cnt, 1);
        chk("lost_serve_inplay", int'(inPlay), 0);
        chk("lost_serve_x", int'(ballTopLeftX), 124);
        chk("lost_serve_y", int'(ballTopLeftY), 400);

        // Reset in the middle of MOVE.
        launch = 1'b1; tick(); launch = 1'b0;
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        resetN = 1'b0;
        #1;
        chk("midmove_reset_x", int'(ballTopLeftX), 24);
        chk("midmove_reset_y", int'(ballTopLeftY), 400);
        chk("midmove_reset_inplay", int'(inPlay), 0);
        tick();
        resetN = 1'b1;
        tick();
        chk("after_reset_serve_x", int'(ballTopLeftX), 124);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
